// File: rtl/mod_counter_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mod_counter_chain_pkg
// Brief   : Shared constants and helpers for the modulo counter chain.
// Revision: 1.0 - initial release
// ============================================================================
package mod_counter_chain_pkg;

    localparam int c_default_digit_w = 4;
    // Widest packed chain value the MSD-first compare can handle.
    localparam int c_max_vec_w       = 64;

    // Bit position of the least significant bit of digit idx.
    function automatic int digit_lsb(input int idx, input int digit_w);
        return idx * digit_w;
    endfunction

    function automatic bit modulus_ok(input int modulus, input int digit_w);
        return (modulus >= 2) && (modulus <= ((1 << digit_w) - 1));
    endfunction

    // a <= b, deciding on the most significant differing digit.
    function automatic logic msd_first_le(input logic [c_max_vec_w-1:0] a,
                                          input logic [c_max_vec_w-1:0] b,
                                          input int num_digits,
                                          input int digit_w);
        logic [c_max_vec_w-1:0] mask;
        logic [c_max_vec_w-1:0] da;
        logic [c_max_vec_w-1:0] db;
        logic                   decided;
        logic                   result;
        mask    = (c_max_vec_w'(1) << digit_w) - c_max_vec_w'(1);
        decided = 1'b0;
        result  = 1'b1;
        for (int i = num_digits - 1; i >= 0; i--) begin
            da = (a >> (i * digit_w)) & mask;
            db = (b >> (i * digit_w)) & mask;
            if (!decided && (da != db)) begin
                decided = 1'b1;
                result  = (da < db);
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter_chain_digit.sv
`default_nettype none
// ============================================================================
// Module  : mod_digit
// Brief   : One modulo-MODULUS up/down digit with synchronous load.
// Revision: 1.0 - initial release
// ============================================================================
module mod_digit #(
    parameter int                 DIGIT_W = 4,
    parameter logic [DIGIT_W-1:0] MODULUS = 4'd10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               up_dn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] value,
    output logic               tc
);

    localparam logic [DIGIT_W-1:0] c_max = MODULUS - 1'b1;

    logic [DIGIT_W-1:0] value_d;
    logic [DIGIT_W-1:0] value_q;

    assign tc    = up_dn ? (value_q == c_max) : (value_q == '0);
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (step) begin
            if (up_dn) begin
                value_d = tc ? '0 : value_q + 1'b1;
            end else begin
                value_d = tc ? c_max : value_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_counter_chain.sv
`default_nettype none
// ============================================================================
// Module  : mod_counter_chain
// Brief   : Cascade of per-digit modulo counters with validated load and a
//           registered chain carry. Optional macro MOD_COUNTER_CHAIN_WRAP_LIMIT_EN
//           wraps the chain at LIMIT instead of the full mixed-radix range.
// Revision: 1.0 - initial release
// ============================================================================
module mod_counter_chain
    import mod_counter_chain_pkg::*;
#(
    parameter int                            NUM_DIGITS = 2,
    parameter int                            DIGIT_W    = c_default_digit_w,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] MOD_LIST   = {4'd6, 4'd10},
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] LIMIT      = {4'd2, 4'd3}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count,
    output logic [NUM_DIGITS-1:0]         stage_tc,
    output logic                          carry_out,
    output logic                          load_err
);

    localparam int c_total_w = NUM_DIGITS * DIGIT_W;

    logic [NUM_DIGITS-1:0] w_digit_ok;
    logic [NUM_DIGITS-1:0] w_step;
    logic [c_total_w-1:0]  w_digit_load_val;
    logic                  w_load_ok;
    logic                  w_advance;
    logic                  w_wrap;
    logic                  w_force;
    logic                  w_digit_load;
    logic                  w_run;

    logic carry_d;
    logic carry_q;
    logic load_err_d;
    logic load_err_q;

    if (NUM_DIGITS < 1) begin : g_bad_num_digits
        $error("mod_counter_chain: NUM_DIGITS must be at least 1");
    end
    if (c_total_w > c_max_vec_w) begin : g_bad_total_w
        $error("mod_counter_chain: NUM_DIGITS*DIGIT_W exceeds 64 bits");
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam logic [DIGIT_W-1:0] c_mod = MOD_LIST[digit_lsb(i, DIGIT_W) +: DIGIT_W];

        if (!modulus_ok(int'(c_mod), DIGIT_W)) begin : g_bad_mod
            $error("mod_counter_chain: modulus of digit %0d out of range", i);
        end

        assign w_digit_ok[i] = (load_val[digit_lsb(i, DIGIT_W) +: DIGIT_W] < c_mod);

        mod_digit #(
            .DIGIT_W (DIGIT_W),
            .MODULUS (c_mod)
        ) u_digit (
            .clk      (clk),
            .reset    (reset),
            .step     (w_step[i]),
            .up_dn    (up_dn),
            .load     (w_digit_load),
            .load_val (w_digit_load_val[digit_lsb(i, DIGIT_W) +: DIGIT_W]),
            .value    (count[digit_lsb(i, DIGIT_W) +: DIGIT_W]),
            .tc       (stage_tc[i])
        );
    end

    assign w_advance = en & ~load;

    always_comb begin
        w_load_ok = &w_digit_ok;
`ifdef MOD_COUNTER_CHAIN_WRAP_LIMIT_EN
        w_load_ok = w_load_ok & msd_first_le(c_max_vec_w'(load_val), c_max_vec_w'(LIMIT),
                                             NUM_DIGITS, DIGIT_W);
        // Down-wrap still happens at all-zero, which is exactly all stages terminal.
        w_wrap    = up_dn ? (count == LIMIT) : (&stage_tc);
        w_force   = w_advance & w_wrap;
`else
        w_wrap    = &stage_tc;
        w_force   = 1'b0;
`endif
    end

    // A limit wrap reuses the digits' load path to jump to 0 or LIMIT.
    always_comb begin
        w_digit_load     = (load & w_load_ok) | w_force;
        w_digit_load_val = load_val;
        if (w_force) begin
`ifdef MOD_COUNTER_CHAIN_WRAP_LIMIT_EN
            w_digit_load_val = up_dn ? '0 : LIMIT;
`else
            w_digit_load_val = '0;
`endif
        end
    end

    // Digit i steps only when every lower digit sits at its terminal value.
    always_comb begin
        w_step = '0;
        w_run  = w_advance & ~w_force;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_step[i] = w_run;
            w_run     = w_run & stage_tc[i];
        end
    end

    always_comb begin
        carry_d    = w_advance & w_wrap;
        load_err_d = load & ~w_load_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign carry_out = carry_q;
    assign load_err  = load_err_q;

endmodule
`default_nettype wire

// File: doc/mod_counter_chain.md
Name: mod_counter_chain

Overview:
- Parametrised cascade of NUM_DIGITS modulo counters with per-digit modulus, up/down counting, whole-chain synchronous load with validation, and a registered chain carry pulse.
- Successor to the single-digit modulo counter in the digital clock datapath.
- Implements a complete time field (e.g. MM:SS, or HH:MM:SS with a wrap limit) in one instance; carry_out feeds the next field's en.

Parameters:
- NUM_DIGITS, 2, number of cascaded digits; digit 0 is least significant; minimum 1.
- DIGIT_W, 4, bits per digit.
- MOD_LIST, {4'd6,4'd10}, packed NUM_DIGITS*DIGIT_W vector of per-digit moduli; digit i occupies bits [i*DIGIT_W +: DIGIT_W]. Each modulus is 2..2^DIGIT_W-1; a modulus outside that range is an elaboration error.
- LIMIT, {4'd2,4'd3}, packed digit vector of the chain's maximum value; used only when WRAP_LIMIT_EN is defined.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- en, input, 1, advance the chain by one step this cycle.
- up_dn, input, 1, 1 = count up, 0 = count down.
- load, input, 1, synchronous parallel load request.
- load_val, input, NUM_DIGITS*DIGIT_W, value to load; packed like MOD_LIST.
- count, output, NUM_DIGITS*DIGIT_W, registered chain value.
- stage_tc, output, NUM_DIGITS, combinational; bit i = digit i at its terminal value for the current up_dn (mod_i-1 when up, 0 when down).
- carry_out, output, 1, registered one-cycle pulse on chain wrap.
- load_err, output, 1, registered one-cycle pulse when a load is rejected.

Behaviour:
- Reset:
  - count=0, carry_out=0, load_err=0.
  - Reset has priority over every other input, including mid-load and mid-wrap.
- Priority: reset > load > en. When load=1, en is ignored that cycle.
- Load:
  - Accepted only if every digit of load_val is < its modulus (and, with WRAP_LIMIT_EN, load_val <= LIMIT as an MSD-first comparison).
  - Accepted: count <= load_val on the next edge; no carry.
  - Rejected: count is unchanged and load_err=1 for exactly one cycle. There are no partial loads.
- Step (en=1, load=0):
  - Digit i changes iff stage_tc[j]=1 for all j<i. Digit 0 always changes.
  - Up: mod_i-1 wraps to 0; otherwise +1.
  - Down: 0 wraps to mod_i-1; otherwise -1.
- Chain wrap:
  - Occurs when en=1, load=0 and all stage_tc=1.
  - carry_out=1 on the following cycle, coincident with the wrapped count.
  - Applies in both directions. In down mode, carry_out is a borrow.
- en=0 and load=0: count holds; carry_out=0.
- Latency:
  - count and carry_out update 1 cycle after the qualifying edge.
  - stage_tc follows count and up_dn with 0 cycles of latency.
- Changing up_dn between enabled cycles is legal and takes effect on the next step.
- Width: all digit arithmetic is performed in DIGIT_W bits; an out-of-range digit value is unreachable.

Optional Feature:
- Macro: MOD_COUNTER_CHAIN_WRAP_LIMIT_EN.
- Defined:
  - Up, count==LIMIT and en: next count=0; carry_out pulses.
  - Down, count==0 and en: next count=LIMIT; carry_out pulses.
  - Natural all-terminal wrap cannot occur if LIMIT is below the full range.
  - Loads above LIMIT are rejected.
  - Example use: hours with NUM_DIGITS=2, MOD_LIST={3,10}, LIMIT={2,3}.
- Undefined: LIMIT is ignored; the chain wraps only at full mixed-radix range.

Decomposition:
- Package mod_counter_chain_pkg:
  - digit-slice helper function (index to bit range);
  - modulus validation function;
  - MSD-first compare function;
  - default DIGIT_W constant.
- Sub-module mod_digit:
  - single digit with modulus parameter, up_dn, step, load and value inputs;
  - outputs value and tc.
  - Instantiated in a generate loop; chain-level load validation, limit compare and carry register stay in the top.

Test Plan:
- Defaults (0..59), reset, then en=1 for 60 cycles, up → count steps 00..59 then 00; carry_out high exactly one cycle, coincident with 00.
- Load 0x59, en=1, up_dn=0 for 3 cycles → 58, 57, 56. Then load 0x00, step down → 59 with carry_out=1.
- Load 0x5A (digit 0 ≥ 10) → load_err pulse; count unchanged. Load with en=1 simultaneously → loaded value wins, no step.
- Assert reset while count=59, en=1 → next count=00; carry_out=0; load_err=0.
- Macro defined, MOD_LIST={3,10}, LIMIT={2,3}:
  - load 0x23, step up → 00 with carry;
  - load 0x24 → load_err;
  - from 00 step down → 23 with carry.
- en toggled 1/0 alternately from 08 → holds on en=0 cycles; stage_tc[0]=1 only while digit 0 = 9 (up).
